// File: rtl/matrix_col_streamer.sv
// Purpose: holds a DIM x DIM operand matrix and streams it column-by-column into the per-lane delay FIFO bank, then flushes with zeros.
// Latency: first column appears the cycle after start; busy for 2*DIM-1 cycles; done pulses in the following cycle.
// Backpressure: none; the FIFO bank is enabled every busy cycle, and wr_en/start are ignored while busy.
module matrix_col_streamer #(
    parameter int DIM  = 8,
    parameter int BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(DIM)-1:0]  wr_row,
    input  logic [DIM*BITS-1:0]     wr_data,
    input  logic [$clog2(DIM)-1:0]  rd_row,
    output logic [DIM*BITS-1:0]     rd_data,
    input  logic                    start,
    output logic [DIM*BITS-1:0]     col_out,
    output logic                    fifo_en,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = $clog2(DIM);
    localparam logic [CW-1:0] LAST_COL   = CW'(DIM - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(DIM - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [DIM*BITS-1:0]    mem_q [DIM];

    // Next-state logic: STREAM walks columns 0..DIM-1, DRAIN counts 0..DIM-2 then flags done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (cnt_q == LAST_COL) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers; reset aborts any sequence without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Matrix store: row writes accepted only in IDLE so a running stream sees a frozen matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                mem_q[r] <= '0;
            end
        end else if (state_q == IDLE && wr_en) begin
            mem_q[wr_row] <= wr_data;
        end
    end

    // Column decode: lane i carries element (i, cnt) while streaming, zero otherwise.
    always_comb begin
        col_out = '0;
        if (state_q == STREAM) begin
            for (int i = 0; i < DIM; i++) begin
                col_out[i*BITS +: BITS] = mem_q[i][int'(cnt_q)*BITS +: BITS];
            end
        end
    end

    assign rd_data = mem_q[rd_row];
    assign busy    = (state_q != IDLE);
    assign fifo_en = busy;
    assign done    = done_q;

endmodule

// File: tb/tb_matrix_col_streamer.sv
// Purpose: scoreboard bench for matrix_col_streamer against a phase-based reference model.
// Latency: expected outputs for each cycle are queued at the preceding falling edge.
// Backpressure: not applicable; outputs are compared every cycle after the rising edge.
module tb_matrix_col_streamer;

    localparam int DIM  = 8;
    localparam int BITS = 8;
    localparam int W    = DIM * BITS;
    localparam int AW   = $clog2(DIM);
    localparam int SEQ  = 2 * DIM - 1;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_row;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_row;
    logic [W-1:0]  rd_data;
    logic          start;
    logic [W-1:0]  col_out;
    logic          fifo_en;
    logic          busy;
    logic          done;

    matrix_col_streamer #(.DIM(DIM), .BITS(BITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .rd_row  (rd_row),
        .rd_data (rd_data),
        .start   (start),
        .col_out (col_out),
        .fifo_en (fifo_en),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] col;
        logic         fe;
        logic         bs;
        logic         dn;
        logic [W-1:0] rd;
    } exp_t;

    exp_t sb[$];

    // Reference model: matrix as rows, plus a phase number 0 (idle) or 1..2*DIM-1 (cycle within a sequence).
    logic [W-1:0] m_mem [DIM];
    int           m_ph;
    bit           m_done;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < DIM; r++) m_mem[r] = '0;
        m_ph   = 0;
        m_done = 0;
    endtask

    function automatic logic [W-1:0] rnd_row();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++) r[i*BITS +: BITS] = BITS'($urandom_range(0, (1 << BITS) - 1));
        return r;
    endfunction

    // One clock of stimulus: drive at the falling edge, advance the model, queue what the next cycle must show.
    task automatic step(input logic we, input logic [AW-1:0] wr, input logic [W-1:0] wd,
                        input logic st, input logic [AW-1:0] rr);
        exp_t e;
        @(negedge clk);
        wr_en   = we;
        wr_row  = wr;
        wr_data = wd;
        start   = st;
        rd_row  = rr;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_done = (m_ph == SEQ);
            if (m_ph == 0) begin
                if (we) m_mem[wr] = wd;
                if (st) m_ph = 1;
            end else if (m_ph == SEQ) begin
                m_ph = 0;
            end else begin
                m_ph++;
            end
        end
        e.col = '0;
        if (m_ph >= 1 && m_ph <= DIM) begin
            for (int i = 0; i < DIM; i++) e.col[i*BITS +: BITS] = m_mem[i][(m_ph-1)*BITS +: BITS];
        end
        e.fe = (m_ph != 0);
        e.bs = (m_ph != 0);
        e.dn = m_done;
        e.rd = m_mem[rr];
        sb.push_back(e);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, AW'($urandom_range(0, DIM-1)));
    endtask

    // Monitor: after every rising edge, pop the queued expectation and compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("col_out", col_out, e.col);
                chk("fifo_en", W'(fifo_en), W'(e.fe));
                chk("busy",    W'(busy),    W'(e.bs));
                chk("done",    W'(done),    W'(e.dn));
                chk("rd_data", rd_data, e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_data = '0;
        start   = 1'b0;
        rd_row  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state: every row reads back zero, outputs idle.
        for (int r = 0; r < DIM; r++) step(1'b0, '0, '0, 1'b0, AW'(r));

        // Load mem[i][j] = DIM*i + j.
        for (int i = 0; i < DIM; i++) begin
            d = '0;
            for (int j = 0; j < DIM; j++) d[j*BITS +: BITS] = BITS'(DIM*i + j);
            step(1'b1, AW'(i), d, 1'b0, AW'(i));
        end

        // Stream it; mid-stream try a write to row 0 and a second start, both must be ignored.
        step(1'b0, '0, '0, 1'b1, '0);
        for (int k = 1; k <= SEQ; k++) begin
            if (k == 3) step(1'b1, '0, {W{1'b1}}, 1'b1, '0);
            else        step(1'b0, '0, '0, 1'b0, '0);
        end
        idle_steps(3);

        // Write row 3 and start in the same cycle; the stream carries the new row.
        step(1'b1, AW'(3), {DIM{8'hAA}}, 1'b1, AW'(3));
        idle_steps(SEQ);
        // Start in the done cycle: back-to-back sequence.
        step(1'b0, '0, '0, 1'b1, AW'(3));
        idle_steps(SEQ);
        idle_steps(2);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) == 0), AW'($urandom_range(0, DIM-1)), rnd_row(),
                 ($urandom_range(0, 9) == 0), AW'($urandom_range(0, DIM-1)));
        end
        idle_steps(SEQ + 1);

        // Reload a nonzero row, then reset in the middle of DRAIN.
        step(1'b1, AW'(5), rnd_row(), 1'b0, AW'(5));
        step(1'b0, '0, '0, 1'b1, AW'(5));
        idle_steps(DIM + 2);
        @(negedge clk);
        rd_row = AW'(5);
        rst_n  = 1'b0;
        #1;
        chk("rst_col_out", col_out, '0);
        chk("rst_fifo_en", W'(fifo_en), '0);
        chk("rst_busy",    W'(busy), '0);
        chk("rst_done",    W'(done), '0);
        chk("rst_rd_data", rd_data, '0);
        model_reset();
        step(1'b0, '0, '0, 1'b0, AW'(5));
        step(1'b0, '0, '0, 1'b0, AW'(5));
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < DIM; r++) step(1'b0, '0, '0, 1'b0, AW'(r));
        idle_steps(2);

        @(posedge clk);
        #2;
        chk("scoreboard_empty", W'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
